// File: rtl/opgc_pkg.sv
// Shared types for the operand gather/reduce block: reduction modes, FSM states
// and a constant clog2 helper used to size the select and result buses.
package opgc_pkg;

    typedef enum logic [1:0] {
        OPGC_SUM = 2'b00,
        OPGC_MAX = 2'b01,
        OPGC_MIN = 2'b10,
        OPGC_XOR = 2'b11
    } opgc_mode_e;

    typedef enum logic [1:0] {
        COLLECT = 2'b00,
        CALC    = 2'b01,
        HOLD    = 2'b10
    } opgc_state_e;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int opgc_clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/opgc_slot.sv
// One operand slot: a WIDTH-bit data register plus its filled flag.
// clr has priority over wr_en so an accepted result always empties the slot.
module opgc_slot #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             filled
);

    always_ff @(posedge clock) begin
        if (!rst_n || clr) begin
            q      <= '0;
            filled <= 1'b0;
        end else if (wr_en) begin
            q      <= d;
            filled <= 1'b1;
        end
    end

endmodule

// File: rtl/opnd_gather_calc.sv
// Operand collector and reducer: fills N_OPND slots, then presents SUM/MAX/MIN/XOR.
// Define OPGC_AUTO_ACK_EN for strobe-style output that ignores res_ready.
module opnd_gather_calc
    import opgc_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int N_OPND = 4,
    localparam int SEL_W  = (opgc_clog2(N_OPND) < 1) ? 1 : opgc_clog2(N_OPND),
    localparam int RES_W  = WIDTH + opgc_clog2(N_OPND)
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  d_in,
    input  logic [SEL_W-1:0]  sel,
    input  logic              capture,
    input  logic [1:0]        mode,
    output logic [RES_W-1:0]  result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N_OPND-1:0] fill_mask,
    output logic              err
);

    opgc_state_e       state;
    logic [WIDTH-1:0]  slot_q [N_OPND];
    logic [N_OPND-1:0] wr_en;
    logic [N_OPND-1:0] next_mask;
    logic              sel_ok;
    logic              slot_clr;
    logic              accept;

    logic [RES_W-1:0]  red_sum;
    logic [WIDTH-1:0]  red_max;
    logic [WIDTH-1:0]  red_min;
    logic [WIDTH-1:0]  red_xor;
    logic [RES_W-1:0]  red_out;

    assign sel_ok = (32'(sel) < 32'(N_OPND));

`ifdef OPGC_AUTO_ACK_EN
    assign accept = (state == HOLD);
`else
    assign accept = (state == HOLD) && res_valid && res_ready;
`endif

    assign slot_clr = accept;

    // Decode the write strobe and predict the mask this capture would produce.
    always_comb begin
        wr_en     = '0;
        next_mask = fill_mask;
        for (int i = 0; i < N_OPND; i++) begin
            if ((state == COLLECT) && capture && (sel == SEL_W'(i))) begin
                wr_en[i]     = 1'b1;
                next_mask[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_OPND; g++) begin : g_slot
        opgc_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clock  (clock),
            .rst_n  (rst_n),
            .clr    (slot_clr),
            .wr_en  (wr_en[g]),
            .d      (d_in),
            .q      (slot_q[g]),
            .filled (fill_mask[g])
        );
    end

    // SUM is carried at full RES_W precision so it cannot wrap.
    always_comb begin
        red_sum = '0;
        red_max = '0;
        red_min = '1;
        red_xor = '0;
        for (int i = 0; i < N_OPND; i++) begin
            red_sum = red_sum + RES_W'(slot_q[i]);
            if (slot_q[i] > red_max) begin
                red_max = slot_q[i];
            end
            if (slot_q[i] < red_min) begin
                red_min = slot_q[i];
            end
            red_xor = red_xor ^ slot_q[i];
        end
        case (opgc_mode_e'(mode))
            OPGC_SUM: red_out = red_sum;
            OPGC_MAX: red_out = RES_W'(red_max);
            OPGC_MIN: red_out = RES_W'(red_min);
            OPGC_XOR: red_out = RES_W'(red_xor);
            default:  red_out = red_sum;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state     <= COLLECT;
            result    <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= capture && ((state != COLLECT) || !sel_ok);
            case (state)
                COLLECT: begin
                    if (capture && sel_ok && (&next_mask)) begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    result    <= red_out;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (accept) begin
                        res_valid <= 1'b0;
                        state     <= COLLECT;
                    end
                end
                default: begin
                    state     <= COLLECT;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/opnd_gather_calc.md
Name: opnd_gather_calc

Overview:
- Parametrised operand collector and reducer.
- Gathers N_OPND operands of WIDTH bits from a shared input bus. Each operand is written into its slot by a select index plus a capture strobe.
- Once every slot is filled, it computes one of four reductions and presents the result on a valid/ready handshake.
- Accepting the result clears all slots for the next round. Sits between the operand-entry front end and the result consumer.

Parameters:
- WIDTH, 4, bits per operand.
- N_OPND, 4, number of operand slots (2..16; need not be a power of 2).
- SEL_W, derived as $clog2(N_OPND) with a minimum of 1; localparam, not overridable.
- RES_W, derived as WIDTH+$clog2(N_OPND); localparam, full-precision result width.

Ports:
- clock  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- d_in  in  WIDTH  operand data.
- sel  in  SEL_W  target slot index.
- capture  in  1  write strobe for d_in into slot sel.
- mode  in  2  reduction: 00 SUM, 01 MAX, 10 MIN, 11 XOR.
- result  out  RES_W  registered reduction result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- fill_mask  out  N_OPND  per-slot filled flags.
- err  out  1  one-cycle pulse when a capture is rejected.

Behaviour:
- Reset (rst_n=0 at an edge): state COLLECT; all slots=0; fill_mask=0; result=0; res_valid=0; err=0. Reset wins over all other inputs, in any state.
- States: COLLECT, CALC, HOLD.
- COLLECT, capture=1 and sel<N_OPND:
  - slot[sel]<=d_in and fill_mask[sel]<=1.
  - Re-capturing an already-filled slot overwrites it; last write wins and the mask bit stays 1.
- COLLECT, capture=1 and sel>=N_OPND: write ignored; err=1 next cycle.
- Leaving COLLECT: when the capture at edge T makes fill_mask all-ones (including the case where that capture fills the last slot), state is CALC after edge T.
- CALC (one cycle):
  - mode is sampled here, not at capture.
  - result<=reduction over all slots; res_valid<=1; state<=HOLD.
  - res_valid is therefore high after edge T+1. Latency from final capture is 2 edges.
- Arithmetic:
  - SUM: unsigned, zero-extended to RES_W; cannot overflow.
  - MAX and MIN: unsigned compare, zero-extended.
  - XOR: bitwise, zero-extended.
- HOLD: result and res_valid hold stable while res_ready=0.
- Handshake (res_valid & res_ready at an edge):
  - Next cycle: res_valid=0, fill_mask=0, slots=0, state=COLLECT.
  - result keeps its last value.
- capture in CALC or HOLD: ignored and err pulses, including a capture in the same cycle as the acceptance. No data is written during these states.
- err is registered and is high for exactly one cycle per rejected capture.
- fill_mask reflects registered slot state at all times.

Optional Feature:
- Macro: OPGC_AUTO_ACK_EN.
- Defined:
  - res_ready is ignored.
  - res_valid is a one-cycle pulse after CALC.
  - Slots and mask auto-clear on the following edge, and the state returns to COLLECT.
  - This provides legacy strobe-style output with no backpressure.
  - Captures during the pulse cycle are rejected with err.
- Undefined: full valid/ready handshake as above.

Decomposition:
- Package opgc_pkg holds:
  - the mode enum (OPGC_SUM, OPGC_MAX, OPGC_MIN, OPGC_XOR);
  - the state enum (COLLECT, CALC, HOLD);
  - a clog2 helper function.
- Sub-module opgc_slot:
  - one WIDTH-bit register plus filled flag;
  - ports: clock, rst_n, clr, wr_en, d, q, filled;
  - instantiated N_OPND times via generate.
- Reduction logic and FSM live in the top level.

Test Plan:
- WIDTH=4, N_OPND=4, mode=SUM, capture 15 into slots 0..3 in consecutive cycles → res_valid 2 edges after last capture, result=60 (6'b111100).
- mode=MAX, operands 3,9,1,7; then mode=MIN on the next round with the same values → result=9, then result=1. Also change mode between final capture and CALC to confirm it is sampled in CALC.
- Capture slot 2=5 then slot 2=11, plus other slots 0 in SUM → result=11, fill_mask=4'b1111 only after all four slots are written.
- Hold res_ready=0 for 10 cycles while pulsing capture → result/res_valid stable, err pulses once per capture, slots unchanged. Raise res_ready → res_valid=0 and fill_mask=0 next cycle.
- N_OPND=3, sel=3 with capture → err=1 for one cycle, fill_mask unchanged. Assert rst_n=0 during HOLD → all outputs 0 after the edge.
- With OPGC_AUTO_ACK_EN, XOR of 4'hA,4'h5,4'hF,4'h0 → res_valid one-cycle pulse, result=0, fill_mask=0 the following cycle with res_ready tied 0.
